src_fmt: RTL and testbench
==========================

Name: src_fmt

Overview:
- Upstream neighbour of the accelerator top; sits between the DMA read stream and the accelerator's src_* stream port.
- Converts each fp32 input word to bfloat16 with round-to-nearest-even, placed in bits [31:16]. Downstream consumes only those bits.
- Regenerates the per-sample last flag from the sample size. Counts samples per batch and reports completion.
- Provides a 2-entry skid buffer so both streams run at one word per cycle.

Parameters:
- SS_W, 12, width of the sample-size (words per sample) input.
- BN_W, 8, width of the samples-per-batch input.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches ss and bn and begins a batch. Ignored while busy.
- ss  in  SS_W  words per sample; value 0 is illegal and treated as 1.
- bn  in  BN_W  samples per batch; value 0 means zero samples: immediate done.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word of the batch is accepted downstream.
- last_err  out  1  sticky; set when input s_last disagrees with the generated last. Cleared by start.
- s_valid  in  1  input stream valid.
- s_data  in  32  fp32 word.
- s_last  in  1  DMA end-of-sample marker; checked only, never forwarded.
- s_ready  out  1  input ready.
- m_valid  out  1  output valid; drives downstream src_valid.
- m_data  out  32  {bf16, 16'h0}.
- m_last  out  1  generated last of each sample.
- m_ready  in  1  output ready.

Behaviour:
Reset (rst_n low, async):
- State IDLE; counters and buffer cleared.
- busy=0, done=0, last_err=0, s_ready=0, m_valid=0, m_data=0, m_last=0.

FSM states:
- IDLE: start moves to RUN if bn!=0. If bn==0, go to DONE.
- RUN: accepts input words.
- DRAIN: entered once all bn*ss words are accepted; waits until the buffer is empty.
- DONE: pulses done for one cycle, then returns to IDLE.

Handshake and buffering:
- Input transfer when s_valid & s_ready; output transfer when m_valid & m_ready.
- s_ready = (state==RUN) & (buffer count<2) & (input words remaining >0).
- 2-entry buffer: latency from input accept to m_valid is 1 cycle.
- Sustains 1 word/cycle with continuous m_ready. Holds m_data/m_last stable while m_valid & !m_ready.
- Simultaneous push and pop at count 1: count stays 1.
- Full (count 2): s_ready=0.
- Empty: m_valid=0.

Counting:
- Word counter wc runs 0..ss-1. The word with wc==ss-1 is tagged m_last=1, then wc wraps to 0 and the sample counter increments.
- The sample counter reaching bn ends RUN. Extra input words are not accepted (s_ready=0).
- last_err is set on an accepted word when s_last != (wc==ss-1).

Rounding, fp32 f to bf16 b:
- If exp==8'hFF: b=f[31:16], and if mantissa!=0, force b[6]=1 (quiet NaN).
- Else: b = f[31:16] + (f[15] & (f[16] | (f[14:0]!=0))). Carry into the exponent is correct, including overflow to Inf.
- Output m_data[15:0] is always 0.

Reset mid-operation: everything returns to IDLE immediately and buffered words are discarded. No done pulse.

start while busy: ignored; does not clear last_err.

Optional Feature:
SRC_FMT_FTZ_EN:
- Defined: inputs with exp==0 (denormal or zero) output signed zero {f[31],15'h0}. Rounding results are unaffected otherwise.
- Undefined: denormals are rounded like normal numbers. Rounding may carry into exp=1, which is correct.

Decomposition:
- Package src_fmt_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the constants BF16_QNAN_BIT=6 and FP32_EXP_MAX=8'hFF;
  - the function fp32_to_bf16_rne.
- One sub-module, src_fmt_skid: the 2-entry valid/ready buffer carrying {last, data}.
- The FSM, counters and rounding stay in src_fmt.

Test Plan:
- Rounding vectors, ss=4 bn=1:
  - 3F80_8000 -> 3F80_0000 (tie, even)
  - 3F81_8000 -> 3F82_0000 (tie, odd)
  - 3F80_8001 -> 3F81_0000
  - 7F7F_FFFF -> 7F80_0000 (overflow to Inf)
  - m_last on the 4th word; done one cycle after the 4th output handshake.
- NaN/Inf: 7F80_0001 -> 7FC0_0000; FF80_0000 -> FF80_0000. With SRC_FMT_FTZ_EN, 0000_0001 -> 0000_0000 and 8040_0000 -> 8000_0000.
- Throughput, ss=3 bn=4:
  - s_valid held high, m_ready high: 12 words in 12 consecutive cycles; m_last on words 3, 6, 9, 12; one done pulse.
  - Then s_ready=0 with s_valid still high.
- Backpressure, ss=2 bn=2: m_ready low for 5 cycles mid-stream -> s_ready drops after 2 buffered words, m_data stable, no loss or duplication, output order preserved.
- Error and boundaries:
  - s_last high on word 2 of ss=3 -> last_err=1, sticky until the next start.
  - bn=0 start -> done 1 cycle later, no data accepted.
- Reset mid-batch: assert rst_n low with 1 word buffered -> m_valid=0 and busy=0 immediately. A new start with ss=1 bn=1 completes normally.

Source files
------------

// File: rtl/src_fmt_pkg.sv
// Shared types and the fp32 -> bf16 round-to-nearest-even helper for src_fmt.
// Optional macro SRC_FMT_FTZ_EN flushes exp==0 inputs to signed zero.
package src_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         BF16_QNAN_BIT = 6;
    localparam logic [7:0] FP32_EXP_MAX  = 8'hFF;

    function automatic logic [15:0] fp32_to_bf16_rne(input logic [31:0] f);
        logic [15:0] b;
        logic        rnd;
        b   = f[31:16];
        rnd = f[15] & (f[16] | (f[14:0] != 15'h0));
        if (f[30:23] == FP32_EXP_MAX) begin
            // Any NaN payload may live only in the dropped bits; force quiet so it stays NaN.
            if (f[22:0] != 23'h0) b[BF16_QNAN_BIT] = 1'b1;
        end
`ifdef SRC_FMT_FTZ_EN
        else if (f[30:23] == 8'h00) begin
            b = {f[31], 15'h0};
        end
`endif
        else begin
            b = b + {15'h0, rnd};
        end
        return b;
    endfunction

endpackage

// File: rtl/src_fmt_skid.sv
// Two-entry valid/ready buffer; output taken straight from storage so it holds
// steady under backpressure, and a push/pop pair in one cycle keeps full rate.
module src_fmt_skid
    import src_fmt_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/src_fmt.sv
// DMA-side formatter: fp32 -> bf16 (RNE) in [31:16], regenerated per-sample last,
// batch sample counting with done pulse. Optional macro SRC_FMT_FTZ_EN (see package).
module src_fmt
    import src_fmt_pkg::*;
#(
    parameter int SS_W = 12,
    parameter int BN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SS_W-1:0] ss,
    input  logic [BN_W-1:0] bn,
    output logic            busy,
    output logic            done,
    output logic            last_err,
    input  logic            s_valid,
    input  logic [31:0]     s_data,
    input  logic            s_last,
    output logic            s_ready,
    output logic            m_valid,
    output logic [31:0]     m_data,
    output logic            m_last,
    input  logic            m_ready
);

    state_t          state;
    logic [SS_W-1:0] ss_m1;
    logic [SS_W-1:0] wc;
    logic [BN_W-1:0] bn_q;
    logic [BN_W-1:0] sc;
    logic            is_last;
    logic            accept;
    logic            buf_ready;
    logic [1:0]      buf_count;
    logic [32:0]     buf_out;

    assign is_last = (wc == ss_m1);
    assign s_ready = (state == RUN) & buf_ready;
    assign accept  = s_valid & s_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign m_last  = buf_out[32];
    assign m_data  = buf_out[31:0];

    src_fmt_skid #(.W(33)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_data   ({is_last, fp32_to_bf16_rne(s_data), 16'h0}),
        .in_ready  (buf_ready),
        .out_valid (m_valid),
        .out_data  (buf_out),
        .out_ready (m_ready),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ss_m1    <= '0;
            wc       <= '0;
            bn_q     <= '0;
            sc       <= '0;
            last_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ss_m1    <= (ss == '0) ? '0 : ss - SS_W'(1);
                    bn_q     <= bn;
                    wc       <= '0;
                    sc       <= '0;
                    last_err <= 1'b0;
                    state    <= (bn == '0) ? DONE : RUN;
                end
                RUN: if (accept) begin
                    if (s_last != is_last) last_err <= 1'b1;
                    if (is_last) begin
                        wc <= '0;
                        sc <= sc + BN_W'(1);
                        if (sc + BN_W'(1) == bn_q) state <= DRAIN;
                    end else begin
                        wc <= wc + SS_W'(1);
                    end
                end
                // Leave as the final word leaves, so done lands the cycle after that handshake.
                DRAIN: if (buf_count == 2'd0 || (buf_count == 2'd1 && m_ready)) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_src_fmt.sv
// Directed + randomized bench for src_fmt against an arithmetic bf16 / stream model.
module tb_src_fmt;
    localparam int SS_W = 12;
    localparam int BN_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [SS_W-1:0] ss = '0;
    logic [BN_W-1:0] bn = '0;
    logic            busy, done, last_err, s_ready, m_valid, m_last;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            m_ready = 1'b0;
    logic [31:0]     s_data = '0;
    logic [31:0]     m_data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] in_w[$];
    logic        in_l[$];

    always #5 clk = ~clk;

    src_fmt #(.SS_W(SS_W), .BN_W(BN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ss(ss), .bn(bn),
        .busy(busy), .done(done), .last_err(last_err),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rounding from plain integer arithmetic on the two halves.
    function automatic logic [15:0] ref_bf16(input logic [31:0] f);
        int unsigned hi, lo, ex;
        hi = f >> 16;
        lo = f & 32'hFFFF;
        ex = (f >> 23) & 32'hFF;
        if (ex == 255) return 16'(((f & 32'h7FFFFF) != 0) ? (hi | 32'h40) : hi);
`ifdef SRC_FMT_FTZ_EN
        if (ex == 0) return 16'((f >> 31) << 15);
`endif
        if (lo > 32'h8000 || (lo == 32'h8000 && hi % 2 == 1)) hi = hi + 1;
        return 16'(hi);
    endfunction

    task automatic fill_rand(input int ss_eff, input int bn_in);
        in_w.delete();
        in_l.delete();
        for (int i = 0; i < ss_eff * bn_in; i++) begin
            logic [31:0] w;
            w = $urandom;
            case ($urandom_range(0, 3))
                1: w[15:0]  = 16'h8000;
                2: w[30:23] = 8'hFF;
                3: w[30:23] = 8'h00;
                default: ;
            endcase
            in_w.push_back(w);
            in_l.push_back((i % ss_eff) == ss_eff - 1);
        end
    endtask

    // vmode: 0 valid whenever words remain, 1 random. rmode: 0 ready, 1 random, 2 stall cycles 2..6.
    task automatic run_stream(input int ss_in, input int bn_in, input int vmode, input int rmode,
                              input int mid_start);
        int          ss_eff, n, sent, got, cyc, wc, first_acc, last_acc;
        logic        exp_err, stall, pl;
        logic [31:0] pd;
        logic [32:0] e;
        logic [32:0] exp_q[$];
        ss_eff = (ss_in == 0) ? 1 : ss_in;
        n = ss_eff * bn_in;
        sent = 0; got = 0; cyc = 0; wc = 0; first_acc = -1; last_acc = -1;
        exp_err = 1'b0; stall = 1'b0; pd = '0; pl = 1'b0;
        ss = SS_W'(ss_in);
        bn = BN_W'(bn_in);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        while (got < n && cyc < 400) begin
            s_valid = (sent < in_w.size()) && (vmode == 0 || $urandom_range(0, 1) == 1);
            s_data  = (sent < in_w.size()) ? in_w[sent] : 32'h0;
            s_last  = (sent < in_l.size()) ? in_l[sent] : 1'b0;
            m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1))
                                   : !(cyc >= 2 && cyc < 7);
            start = (mid_start != 0 && cyc == mid_start);
            if (start) begin
                ss = SS_W'(1);
                bn = '0;
            end
            #1;
            chk("s_ready", s_ready, (sent < n) && (sent - got < 2));
            chk("m_valid", m_valid, (sent - got) > 0);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            if (stall) begin
                chk("hold_data", m_data, pd);
                chk("hold_last", m_last, pl);
            end
            stall = m_valid & !m_ready;
            pd = m_data;
            pl = m_last;
            if (s_valid && s_ready) begin
                exp_q.push_back({wc == ss_eff - 1, ref_bf16(s_data), 16'h0});
                if (s_last != (wc == ss_eff - 1)) exp_err = 1'b1;
                wc = (wc == ss_eff - 1) ? 0 : wc + 1;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e[31:0]);
                    chk("m_last", m_last, {31'h0, e[32]});
                end
                got++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        #1;
        chk("timeout", got, n);
        chk("done_pulse", done, 1);
        chk("s_ready_end", s_ready, 0);
        chk("last_err", last_err, exp_err);
        if (vmode == 0 && rmode == 0 && n > 0) chk("throughput", last_acc - first_acc, n - 1);
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("last_err_hold", last_err, exp_err);
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", last_err, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Rounding vectors: ties to even/odd, sticky round-up, overflow to Inf
        in_w = '{32'h3F80_8000, 32'h3F81_8000, 32'h3F80_8001, 32'h7F7F_FFFF};
        in_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(4, 1, 0, 0, 0);

        // NaN quieting, -Inf passthrough, denormals
        in_w = '{32'h7F80_0001, 32'hFF80_0000, 32'h0000_0001, 32'h8040_0000};
        in_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(4, 1, 0, 0, 0);

        // Throughput with two surplus words keeping s_valid high past the batch
        fill_rand(3, 4);
        in_w.push_back(32'h1234_5678); in_l.push_back(1'b0);
        in_w.push_back(32'h9ABC_DEF0); in_l.push_back(1'b0);
        run_stream(3, 4, 0, 0, 0);

        // Backpressure
        fill_rand(2, 2);
        run_stream(2, 2, 0, 2, 0);

        // Wrong s_last on word 2, plus a start while busy that must not clear it
        in_w = '{32'h4049_0FDB, 32'hC2F6_E979, 32'h3EAA_AAAB};
        in_l = '{1'b0, 1'b1, 1'b1};
        run_stream(3, 1, 0, 0, 2);

        // bn=0: immediate done, no data; the new start clears last_err
        in_w.delete(); in_l.delete();
        run_stream(3, 0, 0, 0, 0);

        // Randomized batches, including ss=0 treated as 1
        for (int b = 0; b < 6; b++) begin
            int rs, rb;
            rs = (b == 0) ? 0 : int'($urandom_range(1, 5));
            rb = int'($urandom_range(1, 4));
            fill_rand((rs == 0) ? 1 : rs, rb);
            run_stream(rs, rb, 1, 1, 0);
        end

        // Reset with one word buffered
        ss = SS_W'(2); bn = BN_W'(2); start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = 32'h3F81_8000; s_last = 1'b0; m_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_data", m_data, {ref_bf16(32'h3F81_8000), 16'h0});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_w = '{32'hBF80_0000};
        in_l = '{1'b1};
        run_stream(1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
